// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO register pair
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic is_div, neg_p, neg_a, dz, sgn;
  logic [WIDTH-1:0] m, a_abs, b_abs, q, r;
  logic [WIDTH:0] msum, shifted, diff;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sgn = ~op[0];
    a_abs = (sgn && op_a[WIDTH-1]) ? -op_a : op_a;
    b_abs = (sgn && op_b[WIDTH-1]) ? -op_b : op_b;
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = shifted - {1'b0, m};
    acc_next = !is_div ? {msum, acc[WIDTH-1:1]}
             : diff[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
             : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod = neg_p ? -acc : acc;
    q = acc[WIDTH-1:0];
    r = acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      neg_p <= 1'b0;
      neg_a <= 1'b0;
      dz <= 1'b0;
      m <= '0;
      acc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (mthi) hi <= op_a;
          if (mtlo) lo <= op_a;
          if (start) begin
            state <= RUN;
            busy <= 1'b1;
            cnt <= '0;
            is_div <= op[1];
            neg_p <= sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_a <= sgn & op_a[WIDTH-1];
            dz <= op[1] && op_b == '0;
            m <= op[1] ? b_abs : a_abs;
            acc <= {{WIDTH{1'b0}}, op[1] ? a_abs : b_abs};
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
          div_zero <= dz;
          // a zero divisor leaves the dividend magnitude as remainder, so re-signing restores raw op_a
          hi <= is_div ? (neg_a ? -r : r) : prod[2*WIDTH-1:WIDTH];
          lo <= is_div ? (dz ? '1 : neg_p ? -q : q) : prod[WIDTH-1:0];
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
